// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator: waveform modes and the
// quarter-wave sine table generator used to populate the ROM at elaboration.
package tone_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_ZERO   = 2'd3
  } tone_mode_e;

  // Entry k of a quarter-wave table, sampled at bin centres so the mirrored
  // quadrants reproduce a symmetric sine without duplicating endpoints.
  function automatic int quarter_sine(input int k, input int width, input int lut_bits);
    real pk;
    real ang;
    pk  = real'((1 << (width - 1)) - 1);
    ang = 3.14159265358979323846 * real'(2 * k + 1) / real'(1 << (lut_bits + 2));
    return $rtoi(pk * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/tone_quarter_lut.sv
// Registered quarter-wave sine ROM: unsigned magnitude out one cycle after addr.
module tone_quarter_lut
  import tone_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LUT_BITS = 8
) (
  input  logic                clk,
  input  logic [LUT_BITS-1:0] addr,
  output logic [WIDTH-2:0]    data
);

  localparam int DEPTH = 1 << LUT_BITS;

  logic [WIDTH-2:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int ENTRY = quarter_sine(k, WIDTH, LUT_BITS);
    assign rom[k] = ENTRY[WIDTH-2:0];
  end

  // NOTE: ROM read register carries no reset so it maps onto block RAM; the
  // pipeline valid bits decide whether its contents matter.
  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/tone_generator.sv
// Strobe-driven NCO test-signal source (sine/square/saw/zero) with amplitude
// scaling and wrap-synchronised retuning. Define TONE_GEN_DITHER_EN for LFSR phase dither.
module tone_generator
  import tone_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   stb_in,
  input  logic                   phase_clr,
  input  logic [PHASE_WIDTH-1:0] inc_in,
  input  logic [1:0]             mode_in,
  input  logic                   cfg_load,
  input  logic [WIDTH-1:0]       amp,
  output logic [WIDTH-1:0]       data_out,
  output logic                   stb_out,
  output logic                   wrap
);

  localparam logic signed [WIDTH-1:0] PK      = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic        [WIDTH-1:0] UNITY   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [PHASE_WIDTH-1:0] phase, inc_active, pend_inc;
  tone_mode_e             mode_active, pend_mode;
  logic                   pend_valid, wrap_pend;

  logic                   accept, carry, apply, pend_valid_n, take_pend;
  logic [PHASE_WIDTH-1:0] phase_sum, pend_inc_n, inc_next;
  tone_mode_e             pend_mode_n;

  assign accept            = stb_in & enable;
  assign {carry, phase_sum} = {1'b0, phase} + {1'b0, inc_active};
  assign pend_valid_n      = cfg_load | pend_valid;
  assign pend_inc_n        = cfg_load ? inc_in : pend_inc;
  assign pend_mode_n       = cfg_load ? tone_mode_e'(mode_in) : pend_mode;
  // Retuning only lands on period boundaries, clears or while idle, so the
  // waveform never shows a mid-period step.
  assign apply             = (accept & carry) | phase_clr | ~enable;
  assign take_pend         = apply & pend_valid_n;
  assign inc_next          = take_pend ? pend_inc_n : inc_active;

  // NOTE: every register below is sequential state, so non-blocking assignments
  // only; blocking here would let later statements see this cycle's new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      inc_active  <= '0;
      mode_active <= MODE_SINE;
      pend_inc    <= '0;
      pend_mode   <= MODE_SINE;
      pend_valid  <= 1'b0;
      wrap_pend   <= 1'b0;
    end else begin
      pend_inc   <= pend_inc_n;
      pend_mode  <= pend_mode_n;
      pend_valid <= pend_valid_n & ~apply;
      if (take_pend) begin
        inc_active  <= pend_inc_n;
        mode_active <= pend_mode_n;
      end
      if (accept) begin
        phase     <= phase_clr ? inc_next : phase_sum;
        wrap_pend <= carry & ~phase_clr;
      end else if (phase_clr) begin
        phase     <= '0;
        wrap_pend <= 1'b1;
      end
    end
  end

  // Quadrant bits plus table address, taken from the (optionally dithered) phase.
  logic [LUT_BITS+1:0] addr_full;

`ifdef TONE_GEN_DITHER_EN
  localparam int DITHER_BITS = PHASE_WIDTH - LUT_BITS - 2;
  localparam logic [PHASE_WIDTH-1:0] DITHER_MASK =
    PHASE_WIDTH'((64'd1 << DITHER_BITS) - 64'd1);

  logic [15:0]            lfsr;
  logic [PHASE_WIDTH-1:0] dither;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign dither    = PHASE_WIDTH'(lfsr) & DITHER_MASK;
  assign addr_full = (LUT_BITS+2)'(((phase_clr ? {PHASE_WIDTH{1'b0}} : phase) + dither)
                                   >> DITHER_BITS);
`else
  assign addr_full = phase_clr ? '0 : phase[PHASE_WIDTH-1 -: LUT_BITS+2];
`endif

  logic [WIDTH-1:0]        saw_src;
  logic signed [WIDTH-1:0] saw, alt;

  assign saw_src = phase_clr ? '0 : phase[PHASE_WIDTH-1 -: WIDTH];
  assign saw     = saw_src ^ MIN_NEG;

  // NOTE: default assigned first so every path drives alt and no latch is inferred.
  always_comb begin
    alt = '0;
    case (mode_active)
      MODE_SQUARE: alt = saw_src[WIDTH-1] ? -PK : PK;
      MODE_SAW:    alt = (saw == MIN_NEG) ? -PK : saw;
      default:     alt = '0;
    endcase
  end

  logic                    s1_valid, s1_wrap, s1_neg, s1_sine;
  logic signed [WIDTH-1:0] s1_alt;
  logic [LUT_BITS-1:0]     s1_addr;
  logic                    s2_valid, s2_wrap, s2_neg, s2_sine;
  logic signed [WIDTH-1:0] s2_alt;
  logic [WIDTH-2:0]        lut_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
      s1_neg   <= 1'b0;
      s1_sine  <= 1'b0;
      s1_alt   <= '0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_wrap  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_sine  <= 1'b0;
      s2_alt   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_wrap <= phase_clr | wrap_pend;
        s1_neg  <= addr_full[LUT_BITS+1];
        s1_sine <= (mode_active == MODE_SINE);
        s1_alt  <= alt;
        s1_addr <= addr_full[LUT_BITS-1:0] ^ {LUT_BITS{addr_full[LUT_BITS]}};
      end
      s2_valid <= s1_valid;
      s2_wrap  <= s1_wrap;
      s2_neg   <= s1_neg;
      s2_sine  <= s1_sine;
      s2_alt   <= s1_alt;
    end
  end

  tone_quarter_lut #(
    .WIDTH    (WIDTH),
    .LUT_BITS (LUT_BITS)
  ) u_lut (
    .clk  (clk),
    .addr (s1_addr),
    .data (lut_q)
  );

  logic signed [WIDTH-1:0] lut_mag, raw, data_next;
  logic        [WIDTH-1:0] amp_sat;
  logic signed [WIDTH:0]   amp_ext;

  assign lut_mag   = {1'b0, lut_q};
  assign raw       = s2_sine ? (s2_neg ? -lut_mag : lut_mag) : s2_alt;
  assign amp_sat   = (amp > UNITY) ? UNITY : amp;
  assign amp_ext   = {1'b0, amp_sat};
  // Gain is capped at unity, so |raw * amp| >> (WIDTH-1) never exceeds PK.
  assign data_next = WIDTH'(((2*WIDTH+1)'(raw) * (2*WIDTH+1)'(amp_ext)) >>> (WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      stb_out  <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      stb_out <= s2_valid;
      wrap    <= s2_valid & s2_wrap;
      if (s2_valid) data_out <= data_next;
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: directed strobes push hand-computed
// samples; a negedge monitor pops and compares every stb_out.
module tb_tone_generator;
  import tone_pkg::*;

  localparam int W  = 16;
  localparam int PW = 24;
  localparam int LB = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic          stb_in    = 1'b0;
  logic          phase_clr = 1'b0;
  logic          cfg_load  = 1'b0;
  logic [PW-1:0] inc_in    = '0;
  logic [1:0]    mode_in   = 2'd0;
  logic [W-1:0]  amp       = 16'd32768;
  logic [W-1:0]  data_out;
  logic          stb_out;
  logic          wrap;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic signed [W-1:0] data;
    int                  wr;    // -1: wrap not checked
    int                  due;
    string               tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  tone_generator #(
    .WIDTH       (W),
    .PHASE_WIDTH (PW),
    .LUT_BITS    (LB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .stb_in    (stb_in),
    .phase_clr (phase_clr),
    .inc_in    (inc_in),
    .mode_in   (mode_in),
    .cfg_load  (cfg_load),
    .amp       (amp),
    .data_out  (data_out),
    .stb_out   (stb_out),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stb_out) begin
      check("never_min_neg", 64'(data_out == 16'h8000), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stb: got sample %0d, expected no sample", $signed(data_out));
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_data"}, $signed(data_out), mon_e.data);
        if (mon_e.wr >= 0) check({mon_e.tag, "_wrap"}, 64'(wrap), mon_e.wr);
        check({mon_e.tag, "_latency"}, cyc, mon_e.due);
      end
    end
  end

  // Called at the negedge where stb_in is raised: the sample lands 3 edges later.
  task automatic push(input int d, input int w, input string tag);
    exp_t e;
    e.data = W'(d);
    e.wr   = w;
    e.due  = cyc + 3;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic strobe(input int d, input int w, input string tag);
    @(negedge clk);
    stb_in = 1'b1;
    push(d, w, tag);
    @(negedge clk);
    stb_in = 1'b0;
  endtask

  // Load and apply a new setting immediately via phase_clr; P restarts at 0.
  task automatic configure(input logic [PW-1:0] inc, input logic [1:0] mode);
    @(negedge clk);
    cfg_load  = 1'b1;
    phase_clr = 1'b1;
    inc_in    = inc;
    mode_in   = mode;
    @(negedge clk);
    cfg_load  = 1'b0;
    phase_clr = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rt_exp[9];
    rt_exp = '{101, 23241, 32767, 23099, -101, -23241, -32767, -23099, 101};

    repeat (2) @(negedge clk);
    check("rst_data", 64'(data_out), 0);
    check("rst_stb", 64'(stb_out), 0);
    check("rst_wrap", 64'(wrap), 0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Sine, four strobes per period
    configure(24'h400000, MODE_SINE);
    strobe(101, 1, "sine0");
    strobe(32767, 0, "sine1");
    strobe(-101, 0, "sine2");
    strobe(-32767, 0, "sine3");
    strobe(101, 1, "sine_wrap");
    drain();

    // Half amplitude: arithmetic shift floors negative values
    amp = 16'd16384;
    configure(24'h400000, MODE_SINE);
    strobe(50, 1, "half0");
    strobe(16383, 0, "half1");
    strobe(-51, 0, "half2");
    strobe(-16384, 0, "half3");
    drain();

    // Gain above unity saturates to unity
    amp = 16'hFFFF;
    configure(24'h400000, MODE_SINE);
    strobe(101, 1, "sat0");
    strobe(32767, 0, "sat1");
    drain();
    amp = 16'd32768;

    // Square, 20-strobe period
    configure(24'd838861, MODE_SQUARE);
    for (int k = 0; k < 20; k++)
      strobe((k < 10) ? 32767 : -32767, (k == 0) ? 1 : 0, $sformatf("square%0d", k));
    strobe(32767, 1, "square_wrap");
    drain();

    // Sawtooth with an ignored strobe while enable is low
    configure(24'h400000, MODE_SAW);
    strobe(-32767, 1, "saw0");
    strobe(-16384, 0, "saw1");
    @(negedge clk);
    enable = 1'b0;
    stb_in = 1'b1;
    @(negedge clk);
    stb_in = 1'b0;
    enable = 1'b1;
    strobe(0, 0, "saw2");
    strobe(16384, 0, "saw3");
    strobe(-32767, 1, "saw_wrap");
    drain();

    configure(24'h400000, MODE_ZERO);
    strobe(0, 1, "zero0");
    drain();

    // Retune mid-period: old step holds until the wrap
    configure(24'h400000, MODE_SINE);
    strobe(101, 1, "rt_a");
    strobe(32767, 0, "rt_b");
    @(negedge clk);
    cfg_load = 1'b1;
    inc_in   = 24'h200000;
    mode_in  = MODE_SINE;
    @(negedge clk);
    cfg_load = 1'b0;
    strobe(-101, 0, "rt_old0");
    strobe(-32767, 0, "rt_old1");
    for (int k = 0; k < 9; k++)
      strobe(rt_exp[k], (k == 0 || k == 8) ? 1 : 0, $sformatf("rt_new%0d", k));
    drain();

    // Reset with two samples in flight
    configure(24'h400000, MODE_SINE);
    @(negedge clk);
    stb_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stb_in = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_data", 64'(data_out), 0);
    check("midrst_stb", 64'(stb_out), 0);
    check("midrst_wrap", 64'(wrap), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    strobe(101, -1, "postrst0");
    strobe(101, -1, "postrst1");
    drain();

    // phase_clr with a strobe at 0x5A0000, new increment loaded the same cycle
    configure(24'h5A0000, MODE_SINE);
    strobe(101, 1, "pc_pre");
    @(negedge clk);
    stb_in    = 1'b1;
    phase_clr = 1'b1;
    cfg_load  = 1'b1;
    inc_in    = 24'h400000;
    mode_in   = MODE_SINE;
    push(101, 1, "pc_clr");
    @(negedge clk);
    stb_in    = 1'b0;
    phase_clr = 1'b0;
    cfg_load  = 1'b0;
    strobe(32767, 0, "pc_next");
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Parametrised, strobe-driven test-signal source. Phase-accumulator (NCO) addressing a quarter-wave sine LUT.
- Generalises the fixed 20-entry 2.5 kHz table generator: programmable frequency, selectable waveform, amplitude scaling, glitch-free retuning.
- Sits between the sample-rate strober and the transmitter data_in/stb_in inputs.

Parameters:
- WIDTH, 16, output sample width (signed two's complement).
- PHASE_WIDTH, 24, phase accumulator width.
- LUT_BITS, 8, log2 of quarter-wave table entries.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  accepts stb_in when high.
- stb_in  in  1  sample-rate strobe.
- phase_clr  in  1  synchronous phase clear.
- inc_in  in  PHASE_WIDTH  requested phase increment.
- mode_in  in  2  requested waveform: 0 sine, 1 square, 2 sawtooth, 3 zero.
- cfg_load  in  1  one-cycle pulse; latches inc_in and mode_in into the pending registers.
- amp  in  WIDTH  unsigned gain; 2^(WIDTH-1) = unity.
- data_out  out  WIDTH  sample.
- stb_out  out  1  sample valid, one cycle.
- wrap  out  1  first sample of a new waveform period.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state:
  - phase P = 0, inc_active = 0, mode_active = sine.
  - Pending registers = 0 / sine, pend_valid = 0.
  - data_out = 0, stb_out = 0, wrap = 0, all pipeline valids cleared.
- Accepted strobe = stb_in && enable.
  - The sample is computed from the current P.
  - P <= P + inc_active, modulo 2^PHASE_WIDTH.
- cfg_load: pending <= {inc_in, mode_in}, pend_valid <= 1. A later cfg_load before the pending values are applied overwrites them.
- Pending values are applied (inc_active/mode_active <= pending, pend_valid <= 0) in exactly three cases:
  - An accepted strobe whose increment carries out of P (wrap). The new values take effect from the next strobe.
  - phase_clr.
  - Any cycle with enable low.
- cfg_load and an apply event in the same cycle: the new cfg_load values are applied.
- phase_clr:
  - Without a strobe: P <= 0.
  - Together with an accepted strobe: the sample uses phase 0, and P <= the newly applied increment.
  - The sample after phase_clr is flagged wrap.
- enable low: stb_in is ignored, P holds, samples already in the pipeline still drain.
- Pipeline latency is 3 cycles, accepted stb_in to stb_out:
  - S1: decode quadrant and LUT address.
  - S2: LUT read and sign.
  - S3: amplitude multiply.
- Sine:
  - Quadrant q = P[MSB:MSB-1]. addr = P[PHASE_WIDTH-3 -: LUT_BITS].
  - Address is mirrored (~addr) for q = 1 and q = 3. Output is negated for q = 2 and q = 3.
  - Table entry k = round(pk·sin(π(2k+1)/2^(LUT_BITS+2))), with pk = 2^(WIDTH-1)-1.
- Square: +pk when P MSB = 0, -pk otherwise.
- Sawtooth: top WIDTH bits of P with the MSB inverted. The value -2^(WIDTH-1) is clamped to -pk.
- Zero: the sample is 0.
- Output magnitude never exceeds pk; -2^(WIDTH-1) is never produced.
- Amplitude:
  - out = (raw × amp) >>> (WIDTH-1), arithmetic shift (truncate toward −∞).
  - amp > 2^(WIDTH-1) saturates to 2^(WIDTH-1).
- wrap is asserted with stb_out for the sample taken from the first phase after a carry or a phase_clr.
- Reset mid-operation: all state returns to reset values immediately, and no stb_out is issued for in-flight samples.

Optional Feature:
- TONE_GEN_DITHER_EN defined: a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset) advances once per accepted strobe. Its low (PHASE_WIDTH-LUT_BITS-2) bits are added to P before address truncation only; P itself is unaffected.
- Not defined: no LFSR; addressing is plain truncation. Latency is 3 cycles in both builds.

Decomposition:
- Package tone_pkg:
  - Mode constants MODE_SINE, MODE_SQUARE, MODE_SAW, MODE_ZERO.
  - Quarter-wave table generation function, parametrised by WIDTH and LUT_BITS.
- One sub-module, tone_quarter_lut: registered ROM, address in, entry out, 1-cycle read.

Test Plan (WIDTH=16, PHASE_WIDTH=24, LUT_BITS=8, amp=32768):
- Sine with inc=2^22: four strobes → data_out 101, 32767, -101, -32767; wrap asserted with the first sample after the 4th strobe; each stb_out 3 cycles after its stb_in.
- Square with inc=838861: 20-strobe period; 10 samples +32767 then 10 samples -32767; no -32768 ever produced.
- Sine with inc=2^22, amp=16384: samples 50, 16383, -51, -16384.
- inc=2^22 running, then cfg_load inc=2^21 at phase 2^23: the next two samples still step by 2^22; after the wrap the step is 2^21 (8 samples per period).
- Assert rst_n low with two samples in flight: stb_out, data_out and wrap go 0 immediately; no stale samples after release; the first sample is from phase 0 with inc 0.
- phase_clr together with stb_in at phase 0x5A0000: the sample equals the phase-0 value 101 and wrap=1; the next sample uses phase inc_active.
